// File: rtl/alu_pkg.sv
// Shared types for the ALU issue block: opcodes, issue FSM states and the flag bundle.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Bit order gives {N,Z,C,V} when the struct is used as a 4-bit vector.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/alu_issue.sv
// Initiator side of the ALU operand/result interface: one operation in flight at a time.
// Optional ALU_DIV0_TRAP_EN: reject DIV with a zero divisor on the error path instead of issuing it.
module alu_issue
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_opcode,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_c,
    input  logic             alu_fz,
    input  logic             alu_fc,
    input  logic             alu_fn,
    input  logic             alu_fv,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic [3:0]       resp_flags,
    output logic             resp_err,
    output logic [3:0]       flags_q
);

    state_t           state_reg;
    logic [WIDTH-1:0] alu_a_reg;
    logic [WIDTH-1:0] alu_b_reg;
    logic [2:0]       alu_opcode_reg;
    logic [WIDTH-1:0] resp_data_reg;
    flags_t           resp_flags_reg;
    logic             resp_err_reg;
    logic             resp_valid_reg;
    flags_t           flags_q_reg;
    flags_t           alu_flags;
    logic             req_reject;

    assign alu_flags = '{n: alu_fn, z: alu_fz, c: alu_fc, v: alu_fv};

    always_comb begin
        req_reject = req_opcode[2];
`ifdef ALU_DIV0_TRAP_EN
        if (req_opcode == 3'(OP_DIV) && req_b == '0) begin
            req_reject = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            alu_opcode_reg <= '0;
            resp_data_reg  <= '0;
            resp_flags_reg <= '0;
            resp_err_reg   <= 1'b0;
            resp_valid_reg <= 1'b0;
            flags_q_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        alu_a_reg      <= req_a;
                        alu_b_reg      <= req_b;
                        alu_opcode_reg <= req_opcode;
                        if (req_reject) begin
                            // Rejected requests skip EXEC; the response is ready next cycle.
                            resp_err_reg   <= 1'b1;
                            resp_data_reg  <= '0;
                            resp_flags_reg <= '0;
                            resp_valid_reg <= 1'b1;
                            state_reg      <= ST_RESP;
                        end else begin
                            state_reg      <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    resp_data_reg  <= alu_c;
                    resp_flags_reg <= alu_flags;
                    resp_err_reg   <= 1'b0;
                    flags_q_reg    <= alu_flags;
                    resp_valid_reg <= 1'b1;
                    state_reg      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: begin
                    resp_valid_reg <= 1'b0;
                    state_reg      <= ST_IDLE;
                end
            endcase
        end
    end

    // Ready only in IDLE, and forced low while reset is asserted.
    assign req_ready  = (state_reg == ST_IDLE) && !reset;
    assign alu_a      = alu_a_reg;
    assign alu_b      = alu_b_reg;
    assign alu_opcode = alu_opcode_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_data  = resp_data_reg;
    assign resp_flags = resp_flags_reg;
    assign resp_err   = resp_err_reg;
    assign flags_q    = flags_q_reg;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a small behavioural ALU attached to the alu_* ports.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_opcode = 3'd0;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic [63:0] alu_a, alu_b, alu_c;
    logic [2:0]  alu_opcode;
    logic        alu_fz, alu_fc, alu_fn, alu_fv;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [63:0] resp_data;
    logic [3:0]  resp_flags;
    logic        resp_err;
    logic [3:0]  flags_q;

    int vecs = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_issue #(.WIDTH(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_c(alu_c), .alu_fz(alu_fz), .alu_fc(alu_fc), .alu_fn(alu_fn), .alu_fv(alu_fv),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_flags(resp_flags), .resp_err(resp_err),
        .flags_q(flags_q)
    );

    // Behavioural ALU; divide by zero returns all ones.
    logic [64:0] wide;
    always_comb begin
        wide   = '0;
        alu_c  = '0;
        alu_fc = 1'b0;
        alu_fv = 1'b0;
        case (alu_opcode)
            3'd0: begin
                wide   = {1'b0, alu_a} + {1'b0, alu_b};
                alu_c  = wide[63:0];
                alu_fc = wide[64];
                alu_fv = (alu_a[63] == alu_b[63]) && (alu_c[63] != alu_a[63]);
            end
            3'd1: begin
                wide   = {1'b0, alu_a} - {1'b0, alu_b};
                alu_c  = wide[63:0];
                alu_fc = ~wide[64];
                alu_fv = (alu_a[63] != alu_b[63]) && (alu_c[63] != alu_a[63]);
            end
            3'd2: alu_c = alu_a * alu_b;
            3'd3: alu_c = (alu_b == '0) ? '1 : alu_a / alu_b;
            default: alu_c = '0;
        endcase
        alu_fz = (alu_c == '0);
        alu_fn = alu_c[63];
    end

    // Present a request and return just after the edge that accepts it.
    task automatic accept(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            vecs++; fails++;
            $display("FAIL accept_timeout req_ready=%0b required=1", req_ready);
        end
        req_opcode = op; req_a = a; req_b = b; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        $display("issue op=%03b a=%0h b=%0h", op, a, b);
    endtask

    task automatic test_reset();
        @(negedge clk);
        vecs++; if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_req_ready got=%0b exp=0", req_ready); end
        vecs++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rst_resp_valid got=%0b exp=0", resp_valid); end
        vecs++; if ({alu_a, alu_b, alu_opcode} !== '0) begin fails++; $display("FAIL rst_alu got=%0h/%0h/%0h exp=0", alu_a, alu_b, alu_opcode); end
        vecs++; if ({resp_data, resp_flags, resp_err, flags_q} !== '0) begin fails++; $display("FAIL rst_resp got=%0h/%0h/%0b/%0h exp=0", resp_data, resp_flags, resp_err, flags_q); end
        reset = 1'b0;
        @(negedge clk);
        vecs++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready got=%0b exp=1", req_ready); end
        $display("reset done");
    endtask

    // Legal op with resp_ready high: EXEC cycle, then one RESP cycle, then IDLE.
    task automatic test_op(input string name, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] exp_data, input logic [3:0] exp_flags);
        resp_ready = 1'b1;
        accept(op, a, b);
        @(negedge clk);
        vecs++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin fails++; $display("FAIL %s_exec valid/ready got=%0b/%0b exp=0/0", name, resp_valid, req_ready); end
        vecs++; if (alu_a !== a || alu_b !== b || alu_opcode !== op) begin fails++; $display("FAIL %s_alu_regs got=%0h/%0h/%0h exp=%0h/%0h/%0h", name, alu_a, alu_b, alu_opcode, a, b, op); end
        @(negedge clk);
        vecs++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin fails++; $display("FAIL %s_resp valid/err got=%0b/%0b exp=1/0", name, resp_valid, resp_err); end
        vecs++; if (resp_data !== exp_data) begin fails++; $display("FAIL %s_data got=%0h exp=%0h", name, resp_data, exp_data); end
        vecs++; if (resp_flags !== exp_flags) begin fails++; $display("FAIL %s_flags got=%04b exp=%04b", name, resp_flags, exp_flags); end
        vecs++; if (flags_q !== exp_flags) begin fails++; $display("FAIL %s_flags_q got=%04b exp=%04b", name, flags_q, exp_flags); end
        @(negedge clk);
        vecs++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL %s_done valid/ready got=%0b/%0b exp=0/1", name, resp_valid, req_ready); end
        $display("resp %s data=%0h flags=%04b", name, resp_data, resp_flags);
    endtask

    // Rejected op: response one cycle after accept, sticky flags untouched.
    task automatic test_err(input string name, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                            input logic [3:0] exp_flags_q);
        resp_ready = 1'b1;
        accept(op, a, b);
        @(negedge clk);
        vecs++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin fails++; $display("FAIL %s_valid/err got=%0b/%0b exp=1/1", name, resp_valid, resp_err); end
        vecs++; if (resp_data !== 64'd0 || resp_flags !== 4'd0) begin fails++; $display("FAIL %s_data/flags got=%0h/%04b exp=0/0000", name, resp_data, resp_flags); end
        vecs++; if (flags_q !== exp_flags_q) begin fails++; $display("FAIL %s_flags_q got=%04b exp=%04b", name, flags_q, exp_flags_q); end
        @(negedge clk);
        vecs++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL %s_done valid/ready got=%0b/%0b exp=0/1", name, resp_valid, req_ready); end
        $display("resp %s err=%0b", name, resp_err);
    endtask

    task automatic test_reset_exec();
        accept(3'd1, 64'd3, 64'd3);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vecs++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rexec_resp_valid cyc%0d got=%0b exp=0", i, resp_valid); end
        end
        vecs++; if (flags_q !== 4'b0000 || req_ready !== 1'b1) begin fails++; $display("FAIL rexec_state flags_q/ready got=%04b/%0b exp=0000/1", flags_q, req_ready); end
        $display("reset during exec done");
    endtask

    task automatic test_back_to_back();
        int t[2];
        int n;
        n = 0;
        resp_ready = 1'b1;
        @(negedge clk);
        req_opcode = 3'd0; req_a = 64'd1; req_b = 64'd1; req_valid = 1'b1;
        for (int i = 0; i < 12 && n < 2; i++) begin
            if (req_ready) begin
                t[n] = cyc;
                n++;
            end
            if (n < 2) @(negedge clk);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        vecs++; if (n !== 2) begin fails++; $display("FAIL b2b_accepts got=%0d exp=2", n); end
        else begin
            vecs++; if (t[1] - t[0] !== 3) begin fails++; $display("FAIL b2b_interval got=%0d exp=3", t[1] - t[0]); end
        end
        repeat (3) @(negedge clk);
        $display("back_to_back interval=%0d", t[1] - t[0]);
    endtask

    task automatic test_backpressure();
        resp_ready = 1'b0;
        accept(3'd1, 64'd1, 64'd2);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vecs++; if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin fails++; $display("FAIL bp_hold%0d valid/ready got=%0b/%0b exp=1/0", i, resp_valid, req_ready); end
            vecs++; if (resp_data !== 64'hFFFF_FFFF_FFFF_FFFF || resp_flags !== 4'b1000 || resp_err !== 1'b0) begin
                fails++; $display("FAIL bp_stable%0d got=%0h/%04b/%0b exp=ffffffffffffffff/1000/0", i, resp_data, resp_flags, resp_err);
            end
        end
        vecs++; if (flags_q !== 4'b1000) begin fails++; $display("FAIL bp_flags_q got=%04b exp=1000", flags_q); end
        reset = 1'b1;
        #1;
        vecs++; if (req_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_in_reset got=%0b exp=0", req_ready); end
        @(negedge clk);
        reset = 1'b0;
        vecs++; if (resp_valid !== 1'b0 || flags_q !== 4'b0000) begin fails++; $display("FAIL bp_after_reset valid/flags_q got=%0b/%04b exp=0/0000", resp_valid, flags_q); end
        @(negedge clk);
        vecs++; if (req_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_after got=%0b exp=1", req_ready); end
        resp_ready = 1'b1;
        $display("backpressure then reset done");
    endtask

    initial begin
        test_reset();
        test_op("add", 3'd0, 64'd5, 64'd3, 64'd8, 4'b0000);
        test_op("sub_zero", 3'd1, 64'd3, 64'd3, 64'd0, 4'b0110);
        test_op("add_wrap", 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b0110);
        test_err("illegal", 3'b101, 64'd7, 64'd9, 4'b0110);
        test_op("mul_trunc", 3'd2, 64'h1_0000_0000, 64'h1_0000_0003, 64'h0000_0003_0000_0000, 4'b0000);
        test_op("add_ovf", 3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b1001);
        test_reset_exec();
`ifdef ALU_DIV0_TRAP_EN
        test_err("div0", 3'd3, 64'd10, 64'd0, 4'b0000);
`else
        test_op("div0", 3'd3, 64'd10, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000);
`endif
        test_op("div", 3'd3, 64'd100, 64'd7, 64'd14, 4'b0000);
        test_back_to_back();
        test_backpressure();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
